// File: rtl/wb_stage_buf_pkg.sv
// Shared definitions for the writeback stage: source-select encodings and the
// default-width queue entry layout.
package wb_pkg;

    // Writeback source select encodings; values >= WB_EXTRA pick extra sources.
    localparam int WB_ALU   = 0;
    localparam int WB_MEM   = 1;
    localparam int WB_PC2   = 2;
    localparam int WB_IMM   = 3;
    localparam int WB_EXTRA = 4;

    // Default register/data geometry of the core this stage sits in.
    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;

    // One pending register-file write at the default geometry.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_buf_if.sv
// MEM/WB-to-register-file bus: the upstream entry handshake plus the
// register-file write port. master = upstream/RF side, slave = writeback stage.
interface wb_stage_buf_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC)
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_we;
    logic [ADDR_W-1:0]         in_waddr;
    logic [SEL_W-1:0]          in_sel;
    logic [NUM_SRC*DATA_W-1:0] in_src;
    logic                      rf_ready;
    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_waddr;
    logic [DATA_W-1:0]         rf_wdata;

    modport master (
        output in_valid, in_we, in_waddr, in_sel, in_src, rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  in_valid, in_we, in_waddr, in_sel, in_src, rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_stage_buf_src_mux.sv
// Writeback source selector: picks slice sel of the packed source bus, or
// returns zero when sel names a source that does not exist in this build.
module wb_src_mux #(
    parameter int DATA_W  = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*DATA_W-1:0] src,
    output logic [DATA_W-1:0]         data
);

    // Compare-and-pick over existing sources; no match leaves the zero default.
    always_comb begin
        data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                data = src[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/wb_stage_buf.sv
// Writeback stage with a DEPTH-entry write queue between MEM/WB and the
// register-file write port, plus NUM_RD bypass lookups into pending writes.
//
// Timing note: rf_ready reaches in_ready combinationally (a pop in this cycle
// frees a slot for a push in the same cycle). Upstream logic must tolerate
// in_ready depending on the register file's rf_ready within the cycle.
module wb_stage_buf
    import wb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int DEPTH   = 4,
    parameter int NUM_RD  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    wb_stage_buf_if.slave              wb,
    input  logic [NUM_RD*ADDR_W-1:0]   byp_raddr,
    output logic [NUM_RD-1:0]          byp_hit,
    output logic [NUM_RD*DATA_W-1:0]   byp_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [DEPTH-1:0]   vld;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;

    logic [DATA_W-1:0]  src_data;
    logic               accept;
    logic               push;
    logic               drain;
    logic               pop;
    logic [DEPTH-1:0]   push_mask;
    logic [DEPTH-1:0]   pop_mask;
    entry_t             head;

    wb_src_mux #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_src_mux (
        .sel  (wb.in_sel),
        .src  (wb.in_src),
        .data (src_data)
    );

    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Accept when a slot is free now or will be freed by this cycle's pop.
    assign wb.in_ready = !full || (wb.rf_ready && !empty);
    assign accept      = wb.in_valid && wb.in_ready;
    // Entries that do not write the register file are consumed without queueing.
    assign push        = accept && wb.in_we;

    // The head drives the write port whenever something is queued; nothing is
    // presented during a reset cycle so flushed writes never reach the RF.
    assign drain = !empty && !rst;
    assign pop   = drain && wb.rf_ready;
    assign head  = mem[rd_ptr];

    assign wb.rf_we    = drain;
    assign wb.rf_waddr = drain ? head.addr : '0;
    assign wb.rf_wdata = drain ? head.data : '0;

    assign push_mask = push ? ({{(DEPTH-1){1'b0}}, 1'b1} << wr_ptr) : '0;
    assign pop_mask  = pop  ? ({{(DEPTH-1){1'b0}}, 1'b1} << rd_ptr) : '0;

    // Queue payload storage; validity is tracked separately so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: wb.in_waddr, data: src_data};
        end
    end

    // Pointers, occupancy and per-entry valid bits. When full with push+pop the
    // same slot is both freed and refilled, so the push mask is applied last.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            vld     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            vld <= (vld & ~pop_mask) | push_mask;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Bypass search: walk entries oldest to youngest from the head so the last
    // match wins, giving the newest pending value for the looked-up register.
    // The entry being popped this cycle is still valid here.
    always_comb begin
        logic [ADDR_W-1:0] raddr;
        logic [PTR_W-1:0]  idx;
        byp_hit  = '0;
        byp_data = '0;
        raddr    = '0;
        idx      = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            raddr = byp_raddr[r*ADDR_W +: ADDR_W];
            for (int a = 0; a < DEPTH; a++) begin
                idx = rd_ptr + PTR_W'(a);
                if (!rst && vld[idx] && (mem[idx].addr == raddr)) begin
                    byp_hit[r]                   = 1'b1;
                    byp_data[r*DATA_W +: DATA_W] = mem[idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Self-checking bench for wb_stage_buf: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_wb_stage_buf;
    import wb_pkg::*;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NS = 4;
    localparam int DP = 4;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Main DUT
    wb_stage_buf_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS)) bus ();
    logic [NR*AW-1:0]       byp_raddr;
    logic [NR-1:0]          byp_hit;
    logic [NR*DW-1:0]       byp_data;
    logic [$clog2(DP+1)-1:0] count;
    logic                   full;
    logic                   empty;

    wb_stage_buf #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .DEPTH(DP), .NUM_RD(NR)) dut (
        .clk(clk), .rst(rst), .wb(bus),
        .byp_raddr(byp_raddr), .byp_hit(byp_hit), .byp_data(byp_data),
        .count(count), .full(full), .empty(empty)
    );

    // Five-source build
    wb_stage_buf_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(5)) bus5 ();
    logic [NR-1:0]          hit5;
    logic [NR*DW-1:0]       data5;
    logic [2:0]             count5;
    logic                   full5, empty5;

    wb_stage_buf #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(5), .DEPTH(DP), .NUM_RD(NR)) dut5 (
        .clk(clk), .rst(rst), .wb(bus5),
        .byp_raddr(byp_raddr), .byp_hit(hit5), .byp_data(data5),
        .count(count5), .full(full5), .empty(empty5)
    );

    // Three-source build
    wb_stage_buf_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(3)) bus3 ();
    logic [NR-1:0]          hit3;
    logic [NR*DW-1:0]       data3;
    logic [2:0]             count3;
    logic                   full3, empty3;

    wb_stage_buf #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(3), .DEPTH(DP), .NUM_RD(NR)) dut3 (
        .clk(clk), .rst(rst), .wb(bus3),
        .byp_raddr(byp_raddr), .byp_hit(hit3), .byp_data(data3),
        .count(count3), .full(full3), .empty(empty3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pending writes as a plain FIFO of {addr,data}
    wb_entry_t    mq[$];
    logic [AW-1:0] clog[$];
    int           m_sz;
    logic         m_ready;
    wb_entry_t    m_ent;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            m_sz    = mq.size();
            m_ready = (m_sz < DP) || (bus.rf_ready && m_sz > 0);
            if (m_sz > 0 && bus.rf_ready) begin
                void'(mq.pop_front());
            end
            if (bus.in_valid && m_ready && bus.in_we) begin
                m_ent.addr = bus.in_waddr;
                m_ent.data = (int'(bus.in_sel) < NS) ? bus.in_src[int'(bus.in_sel)*DW +: DW] : '0;
                mq.push_back(m_ent);
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    int             e_sz;
    logic           e_we;
    logic [NR-1:0]  e_hit;
    logic [NR*DW-1:0] e_data;

    always @(negedge clk) begin
        if (chk_en) begin
            e_sz   = mq.size();
            e_we   = (e_sz > 0) && !rst;
            e_hit  = '0;
            e_data = '0;
            if (!rst) begin
                for (int r = 0; r < NR; r++) begin
                    for (int i = 0; i < e_sz; i++) begin
                        if (mq[i].addr == byp_raddr[r*AW +: AW]) begin
                            e_hit[r] = 1'b1;
                            e_data[r*DW +: DW] = mq[i].data;
                        end
                    end
                end
            end
            chk("count", 64'(count), 64'(e_sz));
            chk("full", 64'(full), 64'(e_sz == DP));
            chk("empty", 64'(empty), 64'(e_sz == 0));
            chk("in_ready", 64'(bus.in_ready), 64'((e_sz < DP) || (bus.rf_ready && e_sz > 0)));
            chk("rf_we", 64'(bus.rf_we), 64'(e_we));
            chk("rf_waddr", 64'(bus.rf_waddr), e_we ? 64'(mq[0].addr) : 64'd0);
            chk("rf_wdata", 64'(bus.rf_wdata), e_we ? 64'(mq[0].data) : 64'd0);
            chk("byp_hit", 64'(byp_hit), 64'(e_hit));
            chk("byp_data", 64'(byp_data), 64'(e_data));
            if (!rst && bus.rf_we && bus.rf_ready) begin
                clog.push_back(bus.rf_waddr);
            end
        end
    end

    initial begin
        rst = 1'b1;
        byp_raddr = '0;
        bus.in_valid = 1'b0; bus.in_we = 1'b0; bus.in_waddr = '0; bus.in_sel = '0;
        bus.in_src = '0; bus.rf_ready = 1'b1;
        bus5.in_valid = 1'b0; bus5.in_we = 1'b0; bus5.in_waddr = '0; bus5.in_sel = '0;
        bus5.in_src = '0; bus5.rf_ready = 1'b1;
        bus3.in_valid = 1'b0; bus3.in_we = 1'b0; bus3.in_waddr = '0; bus3.in_sel = '0;
        bus3.in_src = '0; bus3.rf_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_rf_we", 64'(bus.rf_we), 64'd0);

        // Single MEM write commits the cycle after acceptance
        bus.in_valid = 1'b1; bus.in_we = 1'b1; bus.in_waddr = 3'd3;
        bus.in_sel = 2'(WB_MEM); bus.in_src = '0; bus.in_src[WB_MEM*DW +: DW] = 16'hBEEF;
        bus.rf_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("t1_rf_we", 64'(bus.rf_we), 64'd1);
        chk("t1_rf_waddr", 64'(bus.rf_waddr), 64'd3);
        chk("t1_rf_wdata", 64'(bus.rf_wdata), 64'hBEEF);
        step();
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_rf_we_off", 64'(bus.rf_we), 64'd0);

        // Fill to full, then push+pop while full
        clog.delete();
        bus.rf_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_we = 1'b1; bus.in_sel = 2'(WB_ALU);
        for (int i = 1; i <= 4; i++) begin
            bus.in_waddr = 3'(i);
            bus.in_src = '0; bus.in_src[15:0] = 16'(i * 16'h0011);
            step();
        end
        bus.in_waddr = 3'd7; bus.in_src = '0; bus.in_src[15:0] = 16'h0077;
        #1;
        chk("t2_full", 64'(full), 64'd1);
        chk("t2_count", 64'(count), 64'd4);
        chk("t2_in_ready_lo", 64'(bus.in_ready), 64'd0);
        step();
        bus.rf_ready = 1'b1;
        #1;
        chk("t2_in_ready_hi", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("t2_count_pp", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) step();
        chk("t2_ncommit", 64'(clog.size()), 64'd5);
        if (clog.size() == 5) begin
            chk("t2_c0", 64'(clog[0]), 64'd1);
            chk("t2_c1", 64'(clog[1]), 64'd2);
            chk("t2_c2", 64'(clog[2]), 64'd3);
            chk("t2_c3", 64'(clog[3]), 64'd4);
            chk("t2_c4", 64'(clog[4]), 64'd7);
        end
        chk("t2_empty", 64'(empty), 64'd1);

        // Two pending writes to r5: bypass returns the newer one
        bus.rf_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_we = 1'b1; bus.in_waddr = 3'd5; bus.in_sel = 2'(WB_ALU);
        bus.in_src = '0; bus.in_src[15:0] = 16'h1111;
        step();
        bus.in_src[15:0] = 16'h2222;
        step();
        bus.in_valid = 1'b0;
        byp_raddr = {3'd6, 3'd5};
        #1;
        chk("t3_hit", 64'(byp_hit), 64'b01);
        chk("t3_data0", 64'(byp_data[15:0]), 64'h2222);
        chk("t3_data1", 64'(byp_data[31:16]), 64'h0);

        // Non-writing entry is accepted and dropped
        bus.in_valid = 1'b1; bus.in_we = 1'b0; bus.in_waddr = 3'd2;
        #1;
        chk("t4_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0; bus.in_we = 1'b1;
        #1;
        chk("t4_count", 64'(count), 64'd2);

        // Drain, then IMM source and extra/out-of-range sources on other builds
        bus.rf_ready = 1'b1;
        step();
        step();
        bus.in_valid = 1'b1; bus.in_we = 1'b1; bus.in_waddr = 3'd4; bus.in_sel = 2'(WB_IMM);
        bus.in_src = {16'h00A5, 16'h0303, 16'h0202, 16'h0101};
        bus5.in_valid = 1'b1; bus5.in_we = 1'b1; bus5.in_waddr = 3'd1; bus5.in_sel = 3'd4;
        bus5.in_src = {16'h5A5A, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus3.in_valid = 1'b1; bus3.in_we = 1'b1; bus3.in_waddr = 3'd2; bus3.in_sel = 2'd3;
        bus3.in_src = {16'h3333, 16'h2222, 16'h1111};
        step();
        bus.in_valid = 1'b0; bus5.in_valid = 1'b0; bus3.in_valid = 1'b0;
        #1;
        chk("t5_imm", 64'(bus.rf_wdata), 64'h00A5);
        chk("t5_src4_we", 64'(bus5.rf_we), 64'd1);
        chk("t5_src4", 64'(bus5.rf_wdata), 64'h5A5A);
        chk("t5_oor_we", 64'(bus3.rf_we), 64'd1);
        chk("t5_oor", 64'(bus3.rf_wdata), 64'h0);
        step();

        // Reset mid-drain flushes all pending writes
        bus.rf_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_we = 1'b1; bus.in_sel = 2'(WB_ALU);
        for (int i = 1; i <= 3; i++) begin
            bus.in_waddr = 3'(i);
            bus.in_src = '0; bus.in_src[15:0] = 16'(i * 16'h1111);
            step();
        end
        bus.in_valid = 1'b0;
        bus.rf_ready = 1'b1;
        step();
        rst = 1'b1;
        #1;
        chk("t6_rst_rf_we", 64'(bus.rf_we), 64'd0);
        step();
        rst = 1'b0;
        byp_raddr = {3'd2, 3'd3};
        #1;
        clog.delete();
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_rf_we", 64'(bus.rf_we), 64'd0);
        chk("t6_hit", 64'(byp_hit), 64'd0);
        for (int i = 0; i < 3; i++) step();
        chk("t6_no_commit", 64'(clog.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
